// File: rtl/buff_pkg.sv
// Shared types and helpers for the buff slot scheduler.
// Optional blink behaviour is selected with the BUFF_BLINK_EN macro.
package buff_pkg;

  typedef enum logic [1:0] {
    SHIELD = 2'd0,
    SPEED  = 2'd1,
    FIRE   = 2'd2,
    LIFE   = 2'd3
  } buff_type_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    ACTIVE = 2'd1,
    BLINK  = 2'd2
  } slot_state_t;

  localparam int unsigned NUM_BUFF_SLOTS = 4;
  localparam int unsigned SLOT_IDX_W     = $clog2(NUM_BUFF_SLOTS);

  function automatic logic [NUM_BUFF_SLOTS-1:0] lowest_onehot(
    input logic [NUM_BUFF_SLOTS-1:0] v
  );
    return v & (~v + NUM_BUFF_SLOTS'(1));
  endfunction

  function automatic logic [SLOT_IDX_W-1:0] onehot_idx(
    input logic [NUM_BUFF_SLOTS-1:0] v
  );
    logic [SLOT_IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < NUM_BUFF_SLOTS; i++) begin
      if (v[i]) idx = SLOT_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/buff_slot.sv
// One buff slot: FREE/ACTIVE/BLINK state, remaining-frame counter and type.
// BLINK is only reachable when BUFF_BLINK_EN is defined.
module buff_slot
  import buff_pkg::*;
#(
  parameter int unsigned LIFETIME_FRAMES = 600
`ifdef BUFF_BLINK_EN
  , parameter int unsigned BLINK_FRAMES  = 120
`endif
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       load,
  input  buff_type_t loadType,
  input  logic       retire,
  input  logic       frameTick,
  output logic       active,
  output logic       blinking,
  output buff_type_t buffType
);

  localparam int unsigned CNT_W = $clog2(LIFETIME_FRAMES + 1);
  localparam logic [CNT_W-1:0] LIFE_C = CNT_W'(LIFETIME_FRAMES);
`ifdef BUFF_BLINK_EN
  localparam logic [CNT_W-1:0] BLINK_C = CNT_W'(BLINK_FRAMES);
`endif

  slot_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  buff_type_t       type_q, type_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    type_d  = type_q;
    case (state_q)
      FREE: begin
        if (load) begin
          state_d = ACTIVE;
          cnt_d   = LIFE_C;
          type_d  = loadType;
        end
      end
      ACTIVE, BLINK: begin
        // Pickup takes precedence over expiry on the same frame tick.
        if (retire) begin
          state_d = FREE;
          cnt_d   = '0;
        end else if (frameTick) begin
          if (cnt_q == '0) begin
            state_d = FREE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
`ifdef BUFF_BLINK_EN
            if (state_q == ACTIVE && cnt_d <= BLINK_C) state_d = BLINK;
`endif
          end
        end
      end
      default: state_d = FREE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= FREE;
      cnt_q   <= '0;
      type_q  <= SHIELD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      type_q  <= type_d;
    end
  end

  assign active   = (state_q != FREE);
  assign blinking = (state_q == BLINK);
  assign buffType = type_q;

endmodule

// File: rtl/buff_slot_scheduler.sv
// Buff slot scheduler: spawn allocation, pickup arbitration and blink timing
// for four buff slots. Define BUFF_BLINK_EN to enable the near-expiry blink.
module buff_slot_scheduler
  import buff_pkg::*;
#(
  parameter int unsigned LIFETIME_FRAMES = 600,
  parameter int unsigned BLINK_FRAMES    = 120,
  parameter int unsigned BLINK_PERIOD    = 8
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       spawnReq,
  input  logic [1:0] spawnType,
  output logic       spawnAck,
  output logic [1:0] spawnSlot,
  input  logic [3:0] tank1Collide,
  input  logic [3:0] tank2Collide,
  output logic [3:0] slotActive,
  output logic [7:0] slotType,
  output logic [3:0] drawEnable,
  output logic       tank1BuffValid,
  output logic       tank2BuffValid,
  output logic [1:0] tank1BuffType,
  output logic [1:0] tank2BuffType
);

  localparam int unsigned N = NUM_BUFF_SLOTS;

  if (LIFETIME_FRAMES < 2 || BLINK_FRAMES >= LIFETIME_FRAMES || BLINK_PERIOD < 1) begin : g_param_check
    $error("buff_slot_scheduler: invalid LIFETIME_FRAMES/BLINK_FRAMES/BLINK_PERIOD");
  end

  logic [N-1:0] slot_active, slot_blink;
  logic [N-1:0] load_vec, retire_vec;
  logic [N-1:0] t1_sel, t2_sel;
  buff_type_t   slot_type [N];

  logic                  spawn_ack_q, spawn_ack_d;
  logic [SLOT_IDX_W-1:0] spawn_slot_q, spawn_slot_d;
  logic                  t1_valid_q, t1_valid_d, t2_valid_q, t2_valid_d;
  buff_type_t            t1_type_q, t1_type_d, t2_type_q, t2_type_d;

  always_comb begin
    load_vec = spawnReq ? lowest_onehot(~slot_active) : '0;
    t1_sel   = lowest_onehot(tank1Collide & slot_active);
    // Tank 2 only loses the slot tank 1 actually takes this cycle.
    t2_sel     = lowest_onehot(tank2Collide & slot_active & ~t1_sel);
    retire_vec = t1_sel | t2_sel;

    spawn_ack_d  = (load_vec != '0);
    spawn_slot_d = spawn_ack_d ? onehot_idx(load_vec) : spawn_slot_q;
    t1_valid_d   = (t1_sel != '0);
    t1_type_d    = t1_valid_d ? slot_type[onehot_idx(t1_sel)] : t1_type_q;
    t2_valid_d   = (t2_sel != '0);
    t2_type_d    = t2_valid_d ? slot_type[onehot_idx(t2_sel)] : t2_type_q;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      spawn_ack_q  <= 1'b0;
      spawn_slot_q <= '0;
      t1_valid_q   <= 1'b0;
      t1_type_q    <= SHIELD;
      t2_valid_q   <= 1'b0;
      t2_type_q    <= SHIELD;
    end else begin
      spawn_ack_q  <= spawn_ack_d;
      spawn_slot_q <= spawn_slot_d;
      t1_valid_q   <= t1_valid_d;
      t1_type_q    <= t1_type_d;
      t2_valid_q   <= t2_valid_d;
      t2_type_q    <= t2_type_d;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_slot
    buff_slot #(
      .LIFETIME_FRAMES(LIFETIME_FRAMES)
`ifdef BUFF_BLINK_EN
      , .BLINK_FRAMES(BLINK_FRAMES)
`endif
    ) u_slot (
      .clk      (clk),
      .resetN   (resetN),
      .load     (load_vec[i]),
      .loadType (buff_type_t'(spawnType)),
      .retire   (retire_vec[i]),
      .frameTick(startOfFrame),
      .active   (slot_active[i]),
      .blinking (slot_blink[i]),
      .buffType (slot_type[i])
    );
    assign slotType[2*i+1:2*i] = slot_type[i];
  end

`ifdef BUFF_BLINK_EN
  localparam int unsigned BW = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_phase_q, blink_phase_d;

  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (startOfFrame) begin
      if (blink_cnt_q == BW'(BLINK_PERIOD - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign drawEnable = slot_active & (~slot_blink | {N{blink_phase_q}});
`else
  assign drawEnable = slot_active & ~slot_blink;
`endif

  assign spawnAck       = spawn_ack_q;
  assign spawnSlot      = spawn_slot_q;
  assign slotActive     = slot_active;
  assign tank1BuffValid = t1_valid_q;
  assign tank1BuffType  = t1_type_q;
  assign tank2BuffValid = t2_valid_q;
  assign tank2BuffType  = t2_type_q;

endmodule

// File: tb/tb_buff_slot_scheduler.sv
// Bench for buff_slot_scheduler; follows BUFF_BLINK_EN the same way the design does.
module tb_buff_slot_scheduler;

  localparam int L  = 10;
  localparam int BF = 4;
  localparam int BP = 2;
`ifdef BUFF_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       startOfFrame = 1'b0;
  logic       spawnReq = 1'b0;
  logic [1:0] spawnType = 2'd0;
  logic       spawnAck;
  logic [1:0] spawnSlot;
  logic [3:0] tank1Collide = 4'd0;
  logic [3:0] tank2Collide = 4'd0;
  logic [3:0] slotActive;
  logic [7:0] slotType;
  logic [3:0] drawEnable;
  logic       tank1BuffValid, tank2BuffValid;
  logic [1:0] tank1BuffType, tank2BuffType;

  buff_slot_scheduler #(
    .LIFETIME_FRAMES(L),
    .BLINK_FRAMES   (BF),
    .BLINK_PERIOD   (BP)
  ) dut (
    .clk           (clk),
    .resetN        (resetN),
    .startOfFrame  (startOfFrame),
    .spawnReq      (spawnReq),
    .spawnType     (spawnType),
    .spawnAck      (spawnAck),
    .spawnSlot     (spawnSlot),
    .tank1Collide  (tank1Collide),
    .tank2Collide  (tank2Collide),
    .slotActive    (slotActive),
    .slotType      (slotType),
    .drawEnable    (drawEnable),
    .tank1BuffValid(tank1BuffValid),
    .tank2BuffValid(tank2BuffValid),
    .tank1BuffType (tank1BuffType),
    .tank2BuffType (tank2BuffType)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: age counts frames since spawn; a buff lives L+1 frame ticks.
  bit m_alive [4];
  int m_age   [4];
  int m_type  [4];
  int sof_total;
  bit e_ack, e_g1, e_g2;
  int e_slot, e_g1t, e_g2t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_alive[i] = 1'b0;
      m_age[i]   = 0;
      m_type[i]  = 0;
    end
    sof_total = 0;
    e_ack = 1'b0; e_g1 = 1'b0; e_g2 = 1'b0;
    e_slot = 0; e_g1t = 0; e_g2t = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_slotActive"}, 32'(slotActive), 32'd0);
    chk({tag, "_drawEnable"}, 32'(drawEnable), 32'd0);
    chk({tag, "_slotType"}, 32'(slotType), 32'd0);
    chk({tag, "_spawnAck"}, 32'(spawnAck), 32'd0);
    chk({tag, "_spawnSlot"}, 32'(spawnSlot), 32'd0);
    chk({tag, "_grants"}, 32'({tank1BuffValid, tank2BuffValid, tank1BuffType, tank2BuffType}), 32'd0);
  endtask

  task automatic check_outputs();
    logic [3:0] ea, ed;
    logic [7:0] st;
    bit ph;
    ea = '0;
    ed = '0;
    st = slotType;
    ph = ((sof_total / BP) % 2) == 0;
    for (int i = 0; i < 4; i++) begin
      ea[i] = m_alive[i];
      ed[i] = m_alive[i] && (!(BLINK_EN && (L - m_age[i]) <= BF) || ph);
    end
    chk("slotActive", 32'(slotActive), 32'(ea));
    chk("drawEnable", 32'(drawEnable), 32'(ed));
    chk("spawnAck", 32'(spawnAck), 32'(e_ack));
    if (e_ack) chk("spawnSlot", 32'(spawnSlot), 32'(e_slot));
    chk("tank1BuffValid", 32'(tank1BuffValid), 32'(e_g1));
    if (e_g1) chk("tank1BuffType", 32'(tank1BuffType), 32'(e_g1t));
    chk("tank2BuffValid", 32'(tank2BuffValid), 32'(e_g2));
    if (e_g2) chk("tank2BuffType", 32'(tank2BuffType), 32'(e_g2t));
    for (int i = 0; i < 4; i++) begin
      if (m_alive[i]) chk("slotType", 32'(st[2*i +: 2]), 32'(m_type[i]));
    end
  endtask

  // Applies the current inputs for one clock, advances the model, checks outputs.
  task automatic tick();
    int a, h1, h2;
    bit req, sof;
    logic [3:0] t1, t2;
    int typ;
    req = spawnReq; sof = startOfFrame; t1 = tank1Collide; t2 = tank2Collide; typ = int'(spawnType);
    a = -1; h1 = -1; h2 = -1;
    for (int i = 0; i < 4; i++) if (h1 < 0 && t1[i] && m_alive[i]) h1 = i;
    for (int i = 0; i < 4; i++) if (h2 < 0 && t2[i] && m_alive[i] && i != h1) h2 = i;
    for (int i = 0; i < 4; i++) if (a < 0 && req && !m_alive[i]) a = i;
    e_ack = (a >= 0);  e_slot = a;
    e_g1  = (h1 >= 0); e_g1t = (h1 >= 0) ? m_type[h1] : 0;
    e_g2  = (h2 >= 0); e_g2t = (h2 >= 0) ? m_type[h2] : 0;
    for (int i = 0; i < 4; i++) begin
      if (i == h1 || i == h2) m_alive[i] = 1'b0;
      else if (m_alive[i] && sof) begin
        if (m_age[i] == L) m_alive[i] = 1'b0;
        else m_age[i]++;
      end
    end
    if (a >= 0) begin
      m_alive[a] = 1'b1; m_age[a] = 0; m_type[a] = typ;
    end
    if (sof) sof_total++;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    spawnReq = 1'b0; startOfFrame = 1'b0; tank1Collide = '0; tank2Collide = '0;
    model_clear();
    #1;
    check_zero("reset");
    @(posedge clk);
    #1;
    resetN = 1'b1;
  endtask

  task automatic spawn(input logic [1:0] t);
    spawnReq = 1'b1; spawnType = t;
    tick();
    spawnReq = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] st;
    @(posedge clk);
    #1;
    do_reset();

    // First spawn lands in slot 0
    spawn(2'd2);
    chk("tp1_ack", 32'(spawnAck), 32'd1);
    chk("tp1_slot", 32'(spawnSlot), 32'd0);
    chk("tp1_active", 32'(slotActive), 32'b0001);
    st = slotType;
    chk("tp1_type", 32'(st[1:0]), 32'd2);
    chk("tp1_draw", 32'(drawEnable), 32'b0001);

    // Fill, then a pending fifth request served after a pickup frees slot 2
    spawn(2'd1); spawn(2'd3); spawn(2'd0);
    spawnReq = 1'b1; spawnType = 2'd1;
    tick();
    chk("full_noack", 32'(spawnAck), 32'd0);
    tank1Collide = 4'b0100;
    tick();
    tank1Collide = '0;
    chk("pick_valid", 32'(tank1BuffValid), 32'd1);
    chk("pick_type", 32'(tank1BuffType), 32'd3);
    tick();
    spawnReq = 1'b0;
    chk("pend_ack", 32'(spawnAck), 32'd1);
    chk("pend_slot", 32'(spawnSlot), 32'd2);
    tick();

    // Same-slot tie goes to tank 1
    tank1Collide = 4'b0001; tank2Collide = 4'b0001;
    tick();
    tank1Collide = '0; tank2Collide = '0;
    chk("tie_t1", 32'(tank1BuffValid), 32'd1);
    chk("tie_t2", 32'(tank2BuffValid), 32'd0);
    chk("tie_free", 32'(slotActive[0]), 32'd0);

    // Multi-hit for tank 2: lowest slot first, next one the following cycle
    tank2Collide = 4'b0110;
    tick();
    chk("multi_first", 32'(slotActive), 32'b1100);
    tick();
    tank2Collide = '0;
    chk("multi_second", 32'(slotActive), 32'b1000);
    tick();

    // Lifetime/blink: one buff through 11 frame ticks
    do_reset();
    spawn(2'd3);
    for (int k = 1; k <= 11; k++) begin
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      if (k == 10) chk("life_k10_alive", 32'(slotActive[0]), 32'd1);
      if (k == 11) chk("life_k11_free", 32'(slotActive[0]), 32'd0);
      tick();
    end

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      startOfFrame = ($urandom_range(0, 4) == 0);
      tank1Collide = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      tank2Collide = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      if (!spawnReq) begin
        if ($urandom_range(0, 2) == 0) begin
          spawnReq = 1'b1; spawnType = 2'($urandom_range(0, 3));
        end
      end else if (e_ack) begin
        spawnReq = ($urandom_range(0, 3) == 0);
        if (spawnReq) spawnType = 2'($urandom_range(0, 3));
      end
      tick();
    end

    // Asynchronous reset mid-life clears everything without a clock edge
    spawnReq = 1'b0; startOfFrame = 1'b0; tank1Collide = '0; tank2Collide = '0;
    spawn(2'd1);
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    resetN = 1'b0;
    #2;
    check_zero("async_rst");
    do_reset();
    spawn(2'd2);
    chk("post_rst_slot", 32'(spawnSlot), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
